stack_alu: RTL and testbench

- Parameterised signed stack-based ALU: an internal LIFO of N-bit words driven by a 3-bit opcode.
- Push loads the input word; pop returns the top word.
- Add/multiply combine the top two entries without modifying the stack.
- Registered result and signed-overflow flag; used as a small compute engine behind a sequencer.

---
 rtl/stack_alu_pkg.sv | 11 +
 rtl/stack_alu_lifo.sv | 39 +++
 rtl/stack_alu.sv | 86 ++++++++
 tb/tb_stack_alu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// rtl/stack_alu_pkg.sv - opcode constants and NOP decode shared by the stack ALU
package stack_alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  function automatic logic is_nop(input logic [2:0] op);
    return ~op[2];
  endfunction
endpackage

// File: rtl/stack_alu_lifo.sv
// rtl/stack_alu_lifo.sv - N-bit LIFO with exposed top/second entries and occupancy
module stack_alu_lifo #(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [N-1:0]             data,
  output logic [N-1:0]             top,
  output logic [N-1:0]             second,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;

  // Index wraps when fewer entries exist; callers only use the value when valid.
  assign top    = mem[AW'(sp - PW'(1))];
  assign second = mem[AW'(sp - PW'(2))];
  assign count  = sp;
  assign full   = (sp == PW'(DEPTH));
  assign empty  = (sp == '0);

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp[AW-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sp <= '0;
    else if (push && !full)  sp <= sp + PW'(1);
    else if (pop && !empty)  sp <= sp - PW'(1);
  end
endmodule

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - signed stack ALU with registered result and overflow flag
// Optional STACK_ALU_STATUS_EN adds stack_full, stack_empty and op_error outputs.
module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input_data,
  input  logic [2:0]   opcode,
  output logic         overflow,
  output logic [N-1:0] output_data
`ifdef STACK_ALU_STATUS_EN
  ,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         op_error
`endif
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [N-1:0]          top, second, sum;
  logic [PW-1:0]         count;
  logic                  full, empty, has_two, push, pop, add_ovf, mul_ovf;
  logic signed [2*N-1:0] prod;

  assign push = (opcode == OP_PUSH) && !full;
  assign pop  = (opcode == OP_POP) && !empty;

  stack_alu_lifo #(.N(N), .DEPTH(DEPTH)) u_lifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .data   (input_data),
    .top    (top),
    .second (second),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign has_two = (count >= PW'(2));
  assign sum     = top + second;
  assign add_ovf = (top[N-1] == second[N-1]) && (sum[N-1] != top[N-1]);
  assign prod    = (2*N)'($signed(top)) * (2*N)'($signed(second));
  // Product fits in N signed bits only if bits [2N-1:N-1] are all copies of the sign.
  assign mul_ovf = (prod[2*N-1:N] != {N{prod[N-1]}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_data <= '0;
      overflow    <= 1'b0;
    end else if (!is_nop(opcode)) begin
      case (opcode)
        OP_ADD: if (has_two) begin
          output_data <= sum;
          overflow    <= add_ovf;
        end
        OP_MUL: if (has_two) begin
          output_data <= prod[N-1:0];
          overflow    <= mul_ovf;
        end
        OP_POP: begin
          overflow <= 1'b0;
          if (!empty) output_data <= top;
        end
        default: overflow <= 1'b0;
      endcase
    end
  end

`ifdef STACK_ALU_STATUS_EN
  assign stack_full  = full;
  assign stack_empty = empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_error <= 1'b0;
    else     op_error <= ((opcode == OP_PUSH) && full) ||
                         ((opcode == OP_POP) && empty) ||
                         (((opcode == OP_ADD) || (opcode == OP_MUL)) && !has_two);
  end
`endif
endmodule

// File: tb/tb_stack_alu.sv
// tb/tb_stack_alu.sv - randomized and directed bench for stack_alu at N=4 and N=32
module tb_stack_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  din4;
  logic [31:0] din32;
  logic [3:0]  out4;
  logic [31:0] out32;
  logic        ovf4, ovf32;

  int errors = 0;
  int checks = 0;

  // Reference model: signed values held exactly, one stack per instance.
  longint      stk [2][$];
  logic [31:0] m_out [2];
  logic        m_ovf [2];
  int          width [2] = '{4, 32};
  int          depth [2] = '{4, 8};

  stack_alu #(.N(4), .DEPTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .input_data  (din4),
    .opcode      (opcode),
    .overflow    (ovf4),
    .output_data (out4)
  );

  stack_alu #(.N(32), .DEPTH(8)) dut32 (
    .clk         (clk),
    .rst         (rst),
    .input_data  (din32),
    .opcode      (opcode),
    .overflow    (ovf32),
    .output_data (out32)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint mask(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sext(input longint v, input int w);
    longint r;
    r = v & mask(w);
    if (r[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic model_op(input int i, input logic [2:0] op, input longint bits);
    longint a, b, r, lo, hi;
    int     w, sz;
    w  = width[i];
    lo = -(longint'(1) << (w - 1));
    hi = (longint'(1) << (w - 1)) - 1;
    sz = stk[i].size();
    case (op)
      3'b100, 3'b101: if (sz >= 2) begin
        a = stk[i][sz-1];
        b = stk[i][sz-2];
        r = (op == 3'b100) ? a + b : a * b;
        m_out[i] = 32'(r & mask(w));
        m_ovf[i] = (r < lo) || (r > hi);
      end
      3'b110: begin
        if (sz < depth[i]) stk[i].push_back(sext(bits, w));
        m_ovf[i] = 1'b0;
      end
      3'b111: begin
        if (sz > 0) m_out[i] = 32'(stk[i].pop_back() & mask(w));
        m_ovf[i] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic [2:0] op, input logic [3:0] d4, input logic [31:0] d32);
    opcode = op;
    din4   = d4;
    din32  = d32;
    @(posedge clk);
    #1;
    model_op(0, op, longint'(d4));
    model_op(1, op, longint'(d32));
    check("out4",  32'(out4),  m_out[0]);
    check("ovf4",  32'(ovf4),  32'(m_ovf[0]));
    check("out32", out32,      m_out[1]);
    check("ovf32", 32'(ovf32), 32'(m_ovf[1]));
  endtask

  // Raises rst between edges and checks that outputs clear before any clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("arst_out4",  32'(out4),  32'd0);
    check("arst_ovf4",  32'(ovf4),  32'd0);
    check("arst_out32", out32,      32'd0);
    check("arst_ovf32", 32'(ovf32), 32'd0);
    for (int i = 0; i < 2; i++) begin
      stk[i].delete();
      m_out[i] = '0;
      m_ovf[i] = 1'b0;
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 3'b000;
    din4   = '0;
    din32  = '0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = '0;
      m_ovf[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_out4",  32'(out4),  32'd0);
    check("rst_ovf4",  32'(ovf4),  32'd0);
    check("rst_out32", out32,      32'd0);
    check("rst_ovf32", 32'(ovf32), 32'd0);
    rst = 1'b0;

    // N=4 arithmetic scenario
    step(3'b110, 4'b1100, 32'h7fff_ffff);
    step(3'b110, 4'b0001, 32'h0000_0002);
    step(3'b100, 4'b0000, 32'd0);
    check("n4_add",  32'(out4), 32'b1101);
    check("n4_addv", 32'(ovf4), 32'd0);
    check("n32_add_ovf", 32'(ovf32), 32'd1);
    step(3'b101, 4'b0000, 32'd0);
    check("n4_mul",  32'(out4), 32'b1100);
    check("n4_mulv", 32'(ovf4), 32'd0);
    step(3'b111, 4'b0000, 32'd0);
    check("n4_pop",  32'(out4), 32'b0001);
    step(3'b110, 4'b1000, 32'd0);
    step(3'b100, 4'b0000, 32'd0);
    check("n4_add2",  32'(out4), 32'b0100);
    check("n4_add2v", 32'(ovf4), 32'd1);
    step(3'b111, 4'b0000, 32'd0);
    check("n4_pop2",  32'(out4), 32'b1000);
    check("n4_pop2v", 32'(ovf4), 32'd0);
    step(3'b110, 4'b0011, 32'd0);
    step(3'b101, 4'b0000, 32'd0);
    check("n4_mul2",  32'(out4), 32'b0100);
    check("n4_mul2v", 32'(ovf4), 32'd1);

    // Async reset then empty/underflow cases
    async_reset();
    step(3'b111, 4'b0000, 32'd0);
    check("empty_pop4",  32'(out4), 32'd0);
    check("empty_pop32", out32,     32'd0);
    step(3'b110, 4'b0101, 32'd5);
    step(3'b100, 4'b0000, 32'd0);
    check("add_one_entry", out32, 32'd0);
    step(3'b010, 4'b0000, 32'd0);
    check("nop_hold", out32, 32'd0);

    // N=32 full stack: 9th push ignored, LIFO drain, extra pop holds
    async_reset();
    for (int k = 1; k <= 9; k++) step(3'b110, 4'(k), 32'(k));
    for (int k = 8; k >= 1; k--) begin
      step(3'b111, 4'b0000, 32'd0);
      check("lifo_pop", out32, 32'(k));
    end
    step(3'b111, 4'b0000, 32'd0);
    check("pop_empty_hold", out32, 32'd1);

    // Randomized traffic with occasional async resets
    for (int n = 0; n < 800; n++) begin
      logic [31:0] d32;
      d32 = $urandom;
      if ($urandom_range(0, 1) == 0) d32 = 32'(sext(longint'(d32), 17));
      if ($urandom_range(0, 49) == 0) async_reset();
      else step(3'($urandom_range(0, 7)), 4'($urandom), d32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
